// File: rtl/matrix_scan_ctrl.sv
// Row-multiplexed matrix scanner: each row is driven for DIV cycles, then one blank cycle.
// Pattern swap and scroll step happen only at the frame boundary (blank cycle of the last row).
module matrix_scan_ctrl #(
    parameter int ROWS          = 4,
    parameter int COLS          = 12,
    parameter int DIV           = 1000,
    parameter int SCROLL_FRAMES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic                    dir,
    input  logic [0:COLS-1]         cin,
    output logic [0:ROWS-1]         row_sel,
    output logic [0:COLS-1]         cout,
    output logic [$clog2(COLS)-1:0] offset,
    output logic                    frame_done
);
    localparam int OW = $clog2(COLS);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(SCROLL_FRAMES - 1);
    localparam logic [OW-1:0] OFF_LAST   = OW'(COLS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [RW-1:0]   r_row, w_row_nxt;
    logic [DW-1:0]   r_dwell, w_dwell_nxt;
    logic [FW-1:0]   r_frame, w_frame_nxt;
    logic [OW-1:0]   r_offset, w_offset_nxt;
    logic [0:COLS-1] r_active, w_active_nxt;
    logic [0:COLS-1] r_shadow, w_shadow_nxt;
    logic            r_pending, w_pending_nxt;
    logic            w_boundary;
    logic [0:ROWS-1] r_row_sel, w_row_sel_nxt;
    logic [0:COLS-1] r_cout, w_cout_nxt;
    logic            r_frame_done, w_frame_done_nxt;
    logic [OW-1:0]   w_shift;

    function automatic logic [0:COLS-1] rotate(input logic [0:COLS-1] pat, input logic [OW-1:0] sh);
        logic [0:COLS-1] res;
        logic [OW-1:0]   idx;
        res = '0;
        for (int j = 0; j < COLS; j++) begin
            idx    = OW'((j + int'(sh)) % COLS);
            res[j] = pat[idx];
        end
        return res;
    endfunction

    always_comb begin
        w_state_nxt   = r_state;
        w_row_nxt     = r_row;
        w_dwell_nxt   = r_dwell;
        w_frame_nxt   = r_frame;
        w_offset_nxt  = r_offset;
        w_active_nxt  = r_active;
        w_shadow_nxt  = r_shadow;
        w_pending_nxt = r_pending;
        w_boundary    = (r_state == BLANK) && (r_row == ROW_LAST);

        if (!en) begin
            w_state_nxt = IDLE;
            w_row_nxt   = '0;
            w_dwell_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = SCAN;
                    w_row_nxt   = '0;
                    w_dwell_nxt = '0;
                end
                SCAN: begin
                    if (r_dwell == DWELL_LAST) begin
                        w_state_nxt = BLANK;
                        w_dwell_nxt = '0;
                    end else begin
                        w_dwell_nxt = r_dwell + 1'b1;
                    end
                end
                BLANK: begin
                    w_state_nxt = SCAN;
                    w_row_nxt   = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_row_nxt   = '0;
                    w_dwell_nxt = '0;
                end
            endcase
        end

        // Nothing is on the display in IDLE, so a load there can bypass the shadow.
        if (r_state == IDLE) begin
            if (load) begin
                w_active_nxt  = cin;
                w_shadow_nxt  = cin;
                w_pending_nxt = 1'b0;
            end
        end else if (w_boundary) begin
            if (load) begin
                w_active_nxt  = cin;
                w_shadow_nxt  = cin;
                w_pending_nxt = 1'b0;
            end else if (r_pending) begin
                w_active_nxt  = r_shadow;
                w_pending_nxt = 1'b0;
            end
        end else if (load) begin
            w_shadow_nxt  = cin;
            w_pending_nxt = 1'b1;
        end

        if (w_boundary) begin
            if (r_frame == FRAME_LAST) begin
                w_frame_nxt = '0;
                if (!dir) begin
                    w_offset_nxt = (r_offset == OFF_LAST) ? '0 : r_offset + 1'b1;
                end else begin
                    w_offset_nxt = (r_offset == '0) ? OFF_LAST : r_offset - 1'b1;
                end
            end else begin
                w_frame_nxt = r_frame + 1'b1;
            end
        end
    end

    // Outputs are decoded from next-state values so they are registered yet aligned with the FSM.
    always_comb begin
        w_row_sel_nxt = '0;
        w_cout_nxt    = '0;
        w_shift       = OW'((int'(w_row_nxt) + int'(w_offset_nxt)) % COLS);
        if (w_state_nxt == SCAN) begin
            for (int r = 0; r < ROWS; r++) begin
                w_row_sel_nxt[r] = (w_row_nxt == RW'(r));
            end
            w_cout_nxt = rotate(w_active_nxt, w_shift);
        end
        w_frame_done_nxt = (w_state_nxt == BLANK) && (w_row_nxt == ROW_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_row        <= '0;
            r_dwell      <= '0;
            r_frame      <= '0;
            r_offset     <= '0;
            r_active     <= '0;
            r_shadow     <= '0;
            r_pending    <= 1'b0;
            r_row_sel    <= '0;
            r_cout       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_dwell      <= w_dwell_nxt;
            r_frame      <= w_frame_nxt;
            r_offset     <= w_offset_nxt;
            r_active     <= w_active_nxt;
            r_shadow     <= w_shadow_nxt;
            r_pending    <= w_pending_nxt;
            r_row_sel    <= w_row_sel_nxt;
            r_cout       <= w_cout_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign row_sel    = r_row_sel;
    assign cout       = r_cout;
    assign offset     = r_offset;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl with ROWS=4, COLS=12, DIV=2, SCROLL_FRAMES=1.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_matrix_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic        dir;
    logic [0:11] cin;
    logic [0:3]  row_sel;
    logic [0:11] cout;
    logic [3:0]  offset;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // First frame after an idle load of 1000_0000_0000 at offset 0.
    logic [3:0]  exp_rs [12] = '{4'h8, 4'h8, 4'h0, 4'h4, 4'h4, 4'h0,
                                 4'h2, 4'h2, 4'h0, 4'h1, 4'h1, 4'h0};
    logic [11:0] exp_co [12] = '{12'h800, 12'h800, 12'h000, 12'h001, 12'h001, 12'h000,
                                 12'h002, 12'h002, 12'h000, 12'h004, 12'h004, 12'h000};

    matrix_scan_ctrl #(
        .ROWS(4),
        .COLS(12),
        .DIV(2),
        .SCROLL_FRAMES(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .load(load),
        .dir(dir),
        .cin(cin),
        .row_sel(row_sel),
        .cout(cout),
        .offset(offset),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] rs, input logic [11:0] co, input logic fd);
        check({tag, ".row_sel"}, 32'(row_sel), 32'(rs));
        check({tag, ".cout"}, 32'(cout), 32'(co));
        check({tag, ".frame_done"}, 32'(frame_done), 32'(fd));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset must dominate en and load.
        rst_n = 1'b0; en = 1'b1; load = 1'b1; dir = 1'b0; cin = 12'hFFF;
        tick(2);
        check_out("reset_hold", 4'h0, 12'h000, 1'b0);
        check("reset_offset", 32'(offset), 32'd0);
        load = 1'b0; en = 1'b0; cin = 12'h000;
        tick(1);
        rst_n = 1'b1; en = 1'b1;
        check("en_sample_cycle", 32'(row_sel), 32'h0);
        tick(1);
        check_out("first_scan", 4'h8, 12'h000, 1'b0);
        en = 1'b0;
        tick(1);
        check_out("idle_after_en0", 4'h0, 12'h000, 1'b0);

        // Idle load goes straight to the active pattern.
        load = 1'b1; cin = 12'h800;
        tick(1);
        load = 1'b0; cin = 12'h000; en = 1'b1;
        check("idle_load_rs", 32'(row_sel), 32'h0);
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check_out($sformatf("frame0_c%0d", i + 1), exp_rs[i], exp_co[i], (i == 11));
        end
        tick(1);
        check_out("frame1_row0", 4'h8, 12'h001, 1'b0);
        check("frame1_offset", 32'(offset), 32'd1);

        // Scroll forward through a full wrap.
        for (int k = 2; k <= 12; k++) begin
            tick(11);
            check($sformatf("scroll_fd_%0d", k), 32'(frame_done), 32'd1);
            tick(1);
            check($sformatf("scroll_off_%0d", k), 32'(offset), 32'(k % 12));
        end
        dir = 1'b1;
        tick(12);
        check("dir1_wrap_offset", 32'(offset), 32'd11);
        check_out("dir1_row0", 4'h8, 12'h400, 1'b0);

        // Mid-frame load must wait for the boundary.
        tick(3);
        check_out("mid_row1_pre", 4'h4, 12'h800, 1'b0);
        load = 1'b1; cin = 12'hF00;
        tick(1);
        load = 1'b0; cin = 12'h000;
        check_out("mid_row1_post", 4'h4, 12'h800, 1'b0);
        tick(2);
        check_out("mid_row2", 4'h2, 12'h001, 1'b0);
        tick(3);
        check_out("mid_row3", 4'h1, 12'h002, 1'b0);
        tick(2);
        check_out("mid_boundary", 4'h0, 12'h000, 1'b1);
        tick(1);
        check_out("new_pat_row0", 4'h8, 12'h3C0, 1'b0);
        check("new_pat_offset", 32'(offset), 32'd10);

        // Load in the boundary cycle applies at that boundary.
        tick(11);
        check("bnd_fd", 32'(frame_done), 32'd1);
        load = 1'b1; cin = 12'h00F;
        tick(1);
        load = 1'b0; cin = 12'h000;
        check_out("bnd_load_row0", 4'h8, 12'hE01, 1'b0);
        check("bnd_load_offset", 32'(offset), 32'd9);

        // Two loads in one frame: the second wins.
        tick(2);
        load = 1'b1; cin = 12'hFFF;
        tick(1);
        load = 1'b0; cin = 12'h000;
        tick(2);
        load = 1'b1; cin = 12'h0F0;
        tick(1);
        load = 1'b0; cin = 12'h000;
        check_out("multi_row2_old", 4'h2, 12'h807, 1'b0);
        tick(6);
        check_out("multi_last_wins", 4'h8, 12'h00F, 1'b0);
        check("multi_offset", 32'(offset), 32'd8);

        // Drop en mid row 2, then restart at row 0 with the same offset.
        tick(6);
        check_out("row2_before_drop", 4'h2, 12'h03C, 1'b0);
        en = 1'b0;
        tick(1);
        check_out("en_drop", 4'h0, 12'h000, 1'b0);
        check("en_drop_offset", 32'(offset), 32'd8);
        tick(1);
        check_out("en_drop_idle", 4'h0, 12'h000, 1'b0);
        en = 1'b1;
        tick(1);
        check_out("re_enable_row0", 4'h8, 12'h00F, 1'b0);
        check("re_enable_offset", 32'(offset), 32'd8);

        // Reset during row 3 with a load pending.
        tick(3);
        load = 1'b1; cin = 12'hABC;
        tick(1);
        load = 1'b0; cin = 12'h000;
        tick(5);
        check_out("row3_before_rst", 4'h1, 12'h078, 1'b0);
        rst_n = 1'b0;
        tick(1);
        check_out("mid_frame_rst", 4'h0, 12'h000, 1'b0);
        check("mid_frame_rst_offset", 32'(offset), 32'd0);
        rst_n = 1'b1;
        tick(1);
        check_out("post_rst_row0", 4'h8, 12'h000, 1'b0);
        tick(11);
        check("post_rst_fd", 32'(frame_done), 32'd1);
        tick(1);
        check("pending_discarded", 32'(cout), 32'h000);
        check("post_rst_offset", 32'(offset), 32'd11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
